// File: rtl/case_9_sdiv_10s_6s_seq.sv
`default_nettype none
//============================================================================
// Module      : case_9_sdiv_10s_6s_seq
// Description : Iterative signed divider (restoring, one quotient bit per
//               clock) with valid/ready handshakes on both sides.
//               quotient = dividend / divisor, remainder = dividend % divisor,
//               truncating toward zero. A zero divisor yields quotient -1,
//               remainder 0 and div_by_zero = 1.
//               Optional macro CASE9_SDIV_DBZ_FAST_EN: a zero divisor skips
//               the iterative steps and completes one edge after accept.
// Revision    : 1.0 - initial release
//============================================================================
module case_9_sdiv_10s_6s_seq #(
   parameter int DIVIDEND_WIDTH = 10,
   parameter int DIVISOR_WIDTH  = 6
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DIVIDEND_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH-1:0]  remainder,
   output logic                      div_by_zero
);

   localparam int c_n     = DIVIDEND_WIDTH;
   localparam int c_m     = DIVISOR_WIDTH;
   localparam int c_cnt_w = $clog2(c_n + 1);

   // The counter walks 0..N-1 for the restoring steps; the value N marks the
   // extra edge that applies sign correction and registers the result.
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_n);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_calc = 2'd1;
   localparam logic [1:0] c_st_done = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;
   logic [c_n-1:0]     r_dvd;     // dividend magnitude, shifts out MSB-first; quotient bits shift in
   logic [c_m-1:0]     r_dvs;     // divisor magnitude
   logic [c_m:0]       r_prem;    // partial remainder
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_qsign;
   logic               r_rsign;
   logic               r_zero;

   logic               w_accept;
   logic [c_n-1:0]     w_dvd_mag;
   logic [c_m-1:0]     w_dvs_mag;
   logic [c_m+1:0]     w_shift;
   logic [c_m:0]       w_diff;
   logic               w_qbit;

   assign w_accept  = in_valid && in_ready;
   assign w_dvd_mag = dividend[c_n-1] ? (-dividend) : dividend;
   assign w_dvs_mag = divisor[c_m-1] ? (-divisor) : divisor;

   // One restoring step: shift in the next dividend bit, trial-subtract.
   assign w_shift = {r_prem, r_dvd[c_n-1]};
   assign w_qbit  = (w_shift >= {2'b00, r_dvs});
   assign w_diff  = w_shift[c_m:0] - {1'b0, r_dvs};

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_accept) begin
               w_state_nxt = c_st_calc;
            end
         end
         c_st_calc: begin
`ifdef CASE9_SDIV_DBZ_FAST_EN
            if (r_zero) begin
               w_state_nxt = c_st_done;
            end else
`endif
            if (r_cnt == c_cnt_last) begin
               w_state_nxt = c_st_done;
            end
         end
         c_st_done: begin
            if (out_ready) begin
               w_state_nxt = c_st_idle;
            end
         end
         default: w_state_nxt = c_st_idle;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready  = (r_state == c_st_idle);
      out_valid = (r_state == c_st_done);
   end

   // Datapath: operand capture, iterative steps and result registration.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_prem      <= '0;
         r_cnt       <= '0;
         r_qsign     <= 1'b0;
         r_rsign     <= 1'b0;
         r_zero      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_dvd   <= w_dvd_mag;
                  r_dvs   <= w_dvs_mag;
                  r_prem  <= '0;
                  r_cnt   <= '0;
                  r_qsign <= dividend[c_n-1] ^ divisor[c_m-1];
                  r_rsign <= dividend[c_n-1];
                  r_zero  <= (divisor == '0);
               end
            end
            c_st_calc: begin
`ifdef CASE9_SDIV_DBZ_FAST_EN
               if (r_zero) begin
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
               end else
`endif
               if (r_cnt == c_cnt_last) begin
                  // A zero divisor ran the steps only to keep latency constant;
                  // its result is forced rather than taken from the datapath.
                  if (r_zero) begin
                     quotient    <= '1;
                     remainder   <= '0;
                     div_by_zero <= 1'b1;
                  end else begin
                     quotient    <= r_qsign ? (-r_dvd) : r_dvd;
                     remainder   <= r_rsign ? (-r_prem[c_m-1:0]) : r_prem[c_m-1:0];
                     div_by_zero <= 1'b0;
                  end
               end else begin
                  r_prem <= w_qbit ? w_diff : w_shift[c_m:0];
                  r_dvd  <= {r_dvd[c_n-2:0], w_qbit};
                  r_cnt  <= r_cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_case_9_sdiv_10s_6s_seq.sv
`default_nettype none
//============================================================================
// Module      : tb_case_9_sdiv_10s_6s_seq
// Description : Self-checking bench for case_9_sdiv_10s_6s_seq. A monitor
//               predicts each result from C-style signed division and checks
//               latency, values and handshakes; directed operations also
//               check hand-computed literals.
// Revision    : 1.0 - initial release
//============================================================================
module tb_case_9_sdiv_10s_6s_seq;

   localparam int N = 10;
   localparam int M = 6;

   logic         ap_clk = 1'b0;
   logic         ap_rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] dividend;
   logic [M-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] quotient;
   logic [M-1:0] remainder;
   logic         div_by_zero;

   int pass_cnt  = 0;
   int total_cnt = 0;

   case_9_sdiv_10s_6s_seq #(
      .DIVIDEND_WIDTH(N),
      .DIVISOR_WIDTH (M)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .dividend   (dividend),
      .divisor    (divisor),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: truncating signed division, zero-divisor convention.
   function automatic void model(input logic signed [N-1:0] a, input logic signed [M-1:0] b,
                                 output logic [N-1:0] q, output logic [M-1:0] r,
                                 output logic z, output int lat);
      int ia;
      int ib;
      ia = int'(a);
      ib = int'(b);
      if (ib == 0) begin
         q = '1;
         r = '0;
         z = 1'b1;
`ifdef CASE9_SDIV_DBZ_FAST_EN
         lat = 1;
`else
         lat = N + 1;
`endif
      end else begin
         q   = N'(ia / ib);
         r   = M'(ia % ib);
         z   = 1'b0;
         lat = N + 1;
      end
   endfunction

   // Monitor: predicts each accepted operation and checks it every cycle.
   logic         busy     = 1'b0;
   logic         lat_done = 1'b0;
   int           lat_cnt  = 0;
   int           exp_lat  = 0;
   logic [N-1:0] exp_q    = '0;
   logic [M-1:0] exp_r    = '0;
   logic         exp_z    = 1'b0;

   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         busy = 1'b0;
      end else if (busy) begin
         lat_cnt++;
         if (out_valid) begin
            if (!lat_done) begin
               check("latency", 32'(lat_cnt), 32'(exp_lat));
               lat_done = 1'b1;
            end
            check("mon_quotient", 32'(quotient), 32'(exp_q));
            check("mon_remainder", 32'(remainder), 32'(exp_r));
            check("mon_div_by_zero", 32'(div_by_zero), 32'(exp_z));
            check("mon_in_ready_done", 32'(in_ready), 32'd0);
            if (out_ready) busy = 1'b0;
         end else begin
            check("mon_in_ready_calc", 32'(in_ready), 32'd0);
         end
      end else begin
         if (out_valid) check("mon_stale_valid", 32'(out_valid), 32'd0);
         if (in_valid && in_ready) begin
            model(dividend, divisor, exp_q, exp_r, exp_z, exp_lat);
            busy     = 1'b1;
            lat_done = 1'b0;
            lat_cnt  = -1;
         end
      end
   end

   // Issue one operation, check literals, optionally stall the consumer.
   task automatic run_op(input logic [N-1:0] a, input logic [M-1:0] b,
                         input logic [N-1:0] q, input logic [M-1:0] r,
                         input logic z, input int hold);
      @(posedge ap_clk); #1;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge ap_clk);
         if (out_valid) break;
      end
      check("timeout_out_valid", 32'(out_valid), 32'd1);
      check("lit_quotient", 32'(quotient), 32'(q));
      check("lit_remainder", 32'(remainder), 32'(r));
      check("lit_div_by_zero", 32'(div_by_zero), 32'(z));
      for (int i = 0; i < hold; i++) begin
         @(posedge ap_clk); #1;
         if (i == 1) begin
            dividend = 10'sd55;
            divisor  = 6'sd3;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge ap_clk); #1;
      out_ready = 1'b0;
      @(negedge ap_clk);
      check("post_out_valid", 32'(out_valid), 32'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      ap_rst_n  = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge ap_clk);
      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_div_by_zero", 32'(div_by_zero), 32'd0);
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;

      run_op(10'sd100,  6'sd7,  10'sd14,  6'sd2,  1'b0, 0);
      run_op(-10'sd100, 6'sd7,  -10'sd14, -6'sd2, 1'b0, 0);
      run_op(10'sd100,  -6'sd7, -10'sd14, 6'sd2,  1'b0, 0);
      run_op(-10'sd100, -6'sd7, 10'sd14,  -6'sd2, 1'b0, 0);
      run_op(10'h200,   6'h3F,  10'h200,  6'h00,  1'b0, 0);
      run_op(10'sd511,  6'h20,  -10'sd15, 6'sd31, 1'b0, 0);
      run_op(10'h200,   6'sd1,  10'h200,  6'h00,  1'b0, 0);
      run_op(10'sd37,   6'sd0,  10'h3FF,  6'h00,  1'b1, 0);
      run_op(10'sd100,  6'sd7,  10'sd14,  6'sd2,  1'b0, 5);

      // Asynchronous reset in the middle of the iterative steps.
      @(posedge ap_clk); #1;
      dividend = 10'sd60;
      divisor  = 6'sd5;
      in_valid = 1'b1;
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge ap_clk);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_quotient", 32'(quotient), 32'd0);
      repeat (2) @(posedge ap_clk);
      #1;
      ap_rst_n = 1'b1;
      repeat (14) begin
         @(negedge ap_clk);
         check("midrst_no_stale", 32'(out_valid), 32'd0);
      end
      run_op(10'sd60, 6'sd5, 10'sd12, 6'sd0, 1'b0, 0);

      repeat (2) @(posedge ap_clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
